// File: rtl/ad7988_controller_if.sv
// Pin-side and sample-side signals of the AD7988-1 read controller.
interface ad7988_controller_if;
   logic        en;
   logic        sdi;
   logic        cnv;
   logic        sck;
   logic        sdo;
   logic [15:0] data;
   logic        data_valid;

   modport master (input en, sdo, output sdi, cnv, sck, data, data_valid);
   modport slave  (output en, sdo, input sdi, cnv, sck, data, data_valid);
endinterface

// File: rtl/ad7988_controller.sv
// AD7988-1 3-wire CS-mode reader: CNV/SCK generation, 16-bit capture, parallel sample out.
// Define AD7988_CONT_EN for free-running conversions while en is high; default is one per en rising edge.
//
// state   | meaning
// IDLE    | waiting for start condition
// CONV    | cnv high, ADC converting
// WAIT_EN | cnv low, SDO settling before first SCK
// SHIFT   | 16 SCK periods, sdo captured on each rising edge
// DONE    | sample published, data_valid high
// QUIET   | idle gap before next conversion
module ad7988_controller #(
   parameter int unsigned CONV_CYCLES  = 240,
   parameter int unsigned EN_CYCLES    = 1,
   parameter int unsigned SCK_HALF     = 1,
   parameter int unsigned QUIET_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   ad7988_controller_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_CONV, S_WAIT_EN, S_SHIFT, S_DONE, S_QUIET
   } state_t;

   localparam logic [15:0] CONV_LOAD  = 16'(CONV_CYCLES - 1);
   localparam logic [15:0] EN_LOAD    = 16'(EN_CYCLES - 1);
   localparam logic [15:0] QUIET_LOAD = 16'(QUIET_CYCLES - 1);
   localparam logic [7:0]  HALF_LOAD  = 8'(SCK_HALF - 1);

   state_t      state, state_nx;
   logic [15:0] tmr, tmr_nx;
   logic [7:0]  half_cnt, half_nx;
   logic [4:0]  phase, phase_nx;
   logic [15:0] shift_q, shift_nx;
   logic        en_q;
   logic        start;
   logic        sck_nx;

`ifdef AD7988_CONT_EN
   assign start = bus.en;
`else
   assign start = bus.en & ~en_q;
`endif

   assign bus.sdi = 1'b1;

   always_comb begin
      state_nx = state;
      tmr_nx   = tmr;
      half_nx  = half_cnt;
      phase_nx = phase;
      shift_nx = shift_q;
      case (state)
         S_IDLE:
            if (start) begin
               state_nx = S_CONV;
               tmr_nx   = CONV_LOAD;
               shift_nx = '0;
            end
         S_CONV:
            if (tmr == '0) begin
               state_nx = S_WAIT_EN;
               tmr_nx   = EN_LOAD;
            end else begin
               tmr_nx = tmr - 16'd1;
            end
         S_WAIT_EN:
            if (tmr == '0) begin
               state_nx = S_SHIFT;
               half_nx  = HALF_LOAD;
               phase_nx = 5'd31;
            end else begin
               tmr_nx = tmr - 16'd1;
            end
         // phase counts half-periods down from 31; odd = sck low, even = sck high
         S_SHIFT:
            if (half_cnt == '0) begin
               if (phase == '0) begin
                  state_nx = S_DONE;
               end else begin
                  phase_nx = phase - 5'd1;
                  half_nx  = HALF_LOAD;
                  if (phase[0])
                     shift_nx = {shift_q[14:0], bus.sdo};
               end
            end else begin
               half_nx = half_cnt - 8'd1;
            end
         S_DONE: begin
            state_nx = S_QUIET;
            tmr_nx   = QUIET_LOAD;
         end
         S_QUIET:
            if (tmr == '0)
               state_nx = S_IDLE;
            else
               tmr_nx = tmr - 16'd1;
         default: state_nx = S_IDLE;
      endcase
      sck_nx = (state_nx == S_SHIFT) && !phase_nx[0];
   end

   // Pin outputs are registered from the next state so they never glitch on state decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         tmr            <= '0;
         half_cnt       <= '0;
         phase          <= '0;
         shift_q        <= '0;
         en_q           <= 1'b0;
         bus.cnv        <= 1'b0;
         bus.sck        <= 1'b0;
         bus.data       <= '0;
         bus.data_valid <= 1'b0;
      end else begin
         state          <= state_nx;
         tmr            <= tmr_nx;
         half_cnt       <= half_nx;
         phase          <= phase_nx;
         shift_q        <= shift_nx;
         en_q           <= bus.en;
         bus.cnv        <= (state_nx == S_CONV);
         bus.sck        <= sck_nx;
         bus.data_valid <= (state_nx == S_DONE);
         if (state_nx == S_DONE)
            bus.data <= shift_nx;
      end
   end

endmodule

// File: tb/tb_ad7988_controller.sv
// Bench for ad7988_controller: ADC behavioural model, timing monitor and directed/random conversions.
module tb_ad7988_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned bad = 0;

   ad7988_controller_if bus ();

   ad7988_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ADC model: MSB presented when cnv falls, next bit after every sck falling edge.
   logic [15:0] adc_q[$];
   logic [15:0] exp_q[$];
   logic [15:0] m_word = '0;
   int          m_idx = 0;
   logic        m_cnv = 1'b0;
   logic        m_sck = 1'b0;

   always @(bus.cnv or bus.sck) begin
      if (m_cnv && !bus.cnv) begin
         if (adc_q.size() != 0) m_word = adc_q.pop_front();
         else                   m_word = 16'($urandom);
         exp_q.push_back(m_word);
         m_idx   = 0;
         bus.sdo = m_word[15];
      end else if (m_sck && !bus.sck) begin
         m_idx++;
         if (m_idx < 16) bus.sdo = m_word[15 - m_idx];
      end
      m_cnv = bus.cnv;
      m_sck = bus.sck;
   end

   // Timing monitor sampled mid-cycle.
   int unsigned cnv_w = 0, last_cnv_w = 0, rises = 0, last_rises = 0;
   int unsigned cnv_rises = 0, cnv_fall_cyc = 0, first_rise_cyc = 0;
   int unsigned dv_cnt = 0, dv_long = 0, sdi_err = 0, sck_cnv_err = 0, data_glitch = 0;
   logic        p_cnv = 1'b0, p_sck = 1'b0, p_dv = 1'b0, p_rst = 1'b0;
   logic [15:0] p_data = '0;

   always @(negedge clk) begin
      if (bus.sdi !== 1'b1) sdi_err++;
      if (bus.cnv === 1'b1 && bus.sck !== 1'b0) sck_cnv_err++;
      if (bus.cnv && !p_cnv) begin cnv_w = 0; rises = 0; cnv_rises++; end
      if (bus.cnv) cnv_w++;
      if (!bus.cnv && p_cnv) begin last_cnv_w = cnv_w; cnv_fall_cyc = cyc; end
      if (bus.sck && !p_sck) begin
         rises++;
         if (rises == 1) first_rise_cyc = cyc;
      end
      if (bus.data_valid === 1'b1) begin
         dv_cnt++;
         last_rises = rises;
         if (p_dv) dv_long++;
      end
      if (rst_n && p_rst && bus.data_valid !== 1'b1 && bus.data !== p_data) data_glitch++;
      p_cnv  = bus.cnv;
      p_sck  = bus.sck;
      p_dv   = bus.data_valid;
      p_rst  = rst_n;
      p_data = bus.data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_dv(input int budget, output logic [15:0] d, output int unsigned c);
      int n = 0;
      d = 'x;
      c = 0;
      while (n < budget) begin
         @(negedge clk);
         n++;
         if (bus.data_valid === 1'b1) begin
            d = bus.data;
            c = cyc;
            return;
         end
      end
      chk("dv_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_sample(input string tag, input logic [15:0] d);
      if (exp_q.size() == 0) chk({tag, "_no_expected"}, 32'd0, 32'd1);
      else                   chk(tag, {16'd0, d}, {16'd0, exp_q.pop_front()});
   endtask

   initial begin
      logic [15:0] d;
      int unsigned c, c0, c1, base, snap;
      int          n;

      bus.en = 1'b0;
      #1 rst_n = 1'b0;
      step(3);
      chk("rst_cnv", bus.cnv, 0);
      chk("rst_sck", bus.sck, 0);
      chk("rst_data", bus.data, 0);
      chk("rst_dv", bus.data_valid, 0);
      chk("rst_sdi", bus.sdi, 1);
      rst_n = 1'b1;
      step(3);

      // Directed A5C3 conversion with latency and pin-timing checks
      adc_q.push_back(16'hA5C3);
      base = dv_cnt;
      c0 = cyc;
      bus.en = 1'b1;
`ifdef AD7988_CONT_EN
      step(5);
      bus.en = 1'b0;
`endif
      wait_dv(400, d, c);
      chk("a5c3_const", d, 16'hA5C3);
      check_sample("a5c3_model", d);
      chk("latency_a5c3", c - c0 + 1, 275);   // count includes the start cycle
      step(1);
      chk("dv_width", bus.data_valid, 0);
      chk("cnv_width", last_cnv_w, 240);
      chk("sck_rises", last_rises, 16);
      chk("first_sck_rise", first_rise_cyc - cnv_fall_cyc, 2);
`ifndef AD7988_CONT_EN
      while (cyc - c0 < 1000) step(1);
      chk("hold_en_one_dv", dv_cnt - base, 1);
      bus.en = 1'b0;
`endif
      step(10);

      // Random words, random en pulse lengths and gaps
      for (int i = 0; i < 4; i++) begin
         adc_q.push_back(16'($urandom));
         c0 = cyc;
         bus.en = 1'b1;
         step($urandom_range(1, 6));
         bus.en = 1'b0;
         wait_dv(400, d, c);
         check_sample("rand_data", d);
         chk("rand_latency", c - c0 + 1, 275);
         step(1);
         chk("rand_rises", last_rises, 16);
         step($urandom_range(5, 40));
      end

      // en dropped 50 cycles into CONV
      adc_q.push_back(16'h1234);
      base = dv_cnt;
      bus.en = 1'b1;
      step(50);
      bus.en = 1'b0;
      wait_dv(400, d, c);
      check_sample("drop_data", d);
      step(1);
      snap = cnv_rises;
      step(600);
      chk("drop_no_restart", cnv_rises - snap, 0);
      chk("drop_one_dv", dv_cnt - base, 1);

      // Reset after 8 bits of SHIFT
      adc_q.push_back(16'h5AA5);
      bus.en = 1'b1;
      step(2);
      bus.en = 1'b0;
      n = 0;
      while (rises < 8 && n < 500) begin
         step(1);
         #1;
         n++;
      end
      chk("reach_8_bits", rises, 8);
      rst_n = 1'b0;
      #1;
      chk("midrst_sck", bus.sck, 0);
      chk("midrst_cnv", bus.cnv, 0);
      chk("midrst_data", bus.data, 0);
      chk("midrst_dv", bus.data_valid, 0);
      exp_q.delete();
      step(3);
      rst_n = 1'b1;
      step(3);
      adc_q.push_back(16'h3C5A);
      c0 = cyc;
      bus.en = 1'b1;
      step(3);
      bus.en = 1'b0;
      wait_dv(400, d, c);
      chk("post_rst_const", d, 16'h3C5A);
      check_sample("post_rst_model", d);
      chk("post_rst_latency", c - c0 + 1, 275);
      step(20);

`ifdef AD7988_CONT_EN
      // Back-to-back conversions while en is held
      adc_q.push_back(16'hFFFF);
      adc_q.push_back(16'h0000);
      bus.en = 1'b1;
      wait_dv(400, d, c);
      chk("cont_ffff", d, 16'hFFFF);
      check_sample("cont_model0", d);
      wait_dv(400, d, c1);
      bus.en = 1'b0;
      chk("cont_0000", d, 16'h0000);
      check_sample("cont_model1", d);
      chk("cont_period", c1 - c, 277);
      step(20);
`endif

      chk("sdi_always_1", sdi_err, 0);
      chk("sck_quiet_in_cnv", sck_cnv_err, 0);
      chk("dv_single_cycle", dv_long, 0);
      chk("data_stable", data_glitch, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ad7988_controller.md
# ad7988_controller

Read-side controller for an AD7988-1 16-bit SAR ADC in 3-wire CS mode without busy indicator. Generates CNV and SCK from the 24 MHz system clock, serially captures 16 bits from SDO, and presents the sample in parallel with a one-cycle valid strobe. Sits between the ADC pins and the sample-processing logic.

## Interface
- CONV_CYCLES, 240: clk cycles CNV held high (≥ tCONV; 10 µs at 24 MHz); range 1..65535.
- EN_CYCLES, 1: clk cycles from CNV falling to the first SCK phase (covers tEN); range 1..255.
- SCK_HALF, 1: clk cycles per SCK half-period (SCK = clk/(2·SCK_HALF)); range 1..255.
- QUIET_CYCLES, 2: idle clk cycles after data_valid before the next conversion may start; range 1..255.
- clk  in  1  system clock, 24 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  acquisition enable (level).
- sdi  out  1  ADC SDI; constant 1 (3-wire mode).
- cnv  out  1  ADC CNV; rising edge starts conversion.
- sck  out  1  ADC serial clock; idles low.
- sdo  in  1  ADC serial data, MSB first; treated as synchronous to clk.
- data  out  16  last captured sample.
- data_valid  out  1  one-cycle pulse when data updates.

## Operation
- Reset (async, rst_n=0): sdi=1, cnv=0, sck=0, data=16'h0000, data_valid=0, state=IDLE, counters and shift register cleared.
- States: IDLE → CONV → WAIT_EN → SHIFT → DONE → QUIET → IDLE.
- IDLE: cnv=0, sck=0. Start condition (see Configuration) → CONV.
- CONV: cnv=1 for exactly CONV_CYCLES clk cycles, then → WAIT_EN.
- WAIT_EN: cnv=0, sck=0 for EN_CYCLES cycles, then → SHIFT.
- SHIFT: 16 SCK periods; each = SCK_HALF cycles low, then SCK_HALF cycles high. sdo is sampled on the clk edge that drives sck 0→1 and shifted in at the LSB end (shift = {shift[14:0], sdo}); first sample is the MSB. After the 16th high phase sck returns low → DONE.
- DONE: one cycle; data ← shift register, data_valid=1. → QUIET.
- QUIET: cnv=0, sck=0 for QUIET_CYCLES cycles; then → IDLE.
- data holds its value until the next DONE; it never changes at any other time.
- en deasserted after a conversion has started: the transaction completes normally (cnv is never truncated, all 16 bits clocked, data_valid issued); no new conversion starts.
- sdi is constant 1 in every state including reset.

## Timing
- Start condition true in IDLE at edge T → cnv=1 from T+1.
- cnv high cycles: exactly CONV_CYCLES.
- First sck rising edge: EN_CYCLES + SCK_HALF cycles after cnv falls.
- data_valid asserted 32·SCK_HALF cycles after SHIFT entry + 1; width exactly 1 cycle.
- Defaults: en-to-data_valid = 1 + 240 + 1 + 32 + 1 = 275 cycles; conversion period in continuous mode = 1+240+1+32+1+2 = 277 cycles (~86.6 kSPS).
- sck never toggles while cnv=1; exactly 16 rising edges per conversion.
- Reset mid-operation: all outputs go to reset values immediately; partially shifted data discarded.

## Configuration
- AD7988_CONT_EN defined: start condition = en==1 in IDLE; controller free-runs back-to-back conversions while en stays high.
- AD7988_CONT_EN undefined: start condition = registered rising edge of en (en==1 and previous-cycle en==0); exactly one conversion per en rising edge; en held high does not retrigger. A rising edge while not in IDLE is ignored.

## Test plan
- ADC model drives 16'hA5C3 MSB first, next bit after each sck falling edge; pulse en → data=16'hA5C3, data_valid high exactly 1 cycle, 275 cycles after start edge.
- Count cnv high width and sck rising edges → 240 cycles, 16 edges, sck=0 throughout cnv high, sdi=1 always.
- ADC model drives 16'hFFFF then 16'h0000 on consecutive conversions (AD7988_CONT_EN, en held high) → data 16'hFFFF then 16'h0000, valid pulses 277 cycles apart.
- Drop en 50 cycles into CONV → conversion completes, one data_valid, then cnv stays 0.
- Assert rst_n=0 during SHIFT after 8 bits → sck=0, cnv=0, data=0, data_valid=0 immediately; after release, next en start yields a full correct 16-bit sample.
- Without AD7988_CONT_EN, hold en high 1000 cycles → exactly one data_valid pulse.
